// File: rtl/tt_sweeper_if.sv
// Bus bundle for the truth-table sweeper: table/expected loading, start
// handshake and the per-vector result stream with sweep statistics.
interface tt_sweeper_if #(
    parameter int N = 4
);
    logic             load;
    logic [2**N-1:0]  tt_in;
    logic [2**N-1:0]  exp_in;
    logic             start;
    logic             busy;
    logic [N-1:0]     vec;
    logic             s;
    logic             vec_valid;
    logic             done;
    logic [N:0]       ones_cnt;
    logic [N:0]       err_cnt;
    logic             err_flag;
    logic [N-1:0]     first_err;

    modport master (
        output load, tt_in, exp_in, start,
        input  busy, vec, s, vec_valid, done, ones_cnt, err_cnt, err_flag, first_err
    );

    modport slave (
        input  load, tt_in, exp_in, start,
        output busy, vec, s, vec_valid, done, ones_cnt, err_cnt, err_flag, first_err
    );
endinterface

// File: rtl/tt_sweeper.sv
// Sequential truth-table engine: walks every N-bit input vector once per
// clock, emits tt[vec], and accumulates ones/mismatch statistics against an
// expected table captured at start.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | accept load/start; results of the last sweep are held
// SWEEP | present one vector per cycle, update counters in the same cycle
// DONE  | one-cycle done pulse, counters final, then back to IDLE
module tt_sweeper #(
    parameter int N = 4
) (
    input logic        clk,
    input logic        rst,
    tt_sweeper_if.slave bus
);
    localparam int W = 1 << N;
    localparam logic [N-1:0] IDX_LAST = {N{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   tt_q, tt_d;
    logic [W-1:0]   exp_q, exp_d;
    logic [N-1:0]   idx_q, idx_d;
    logic [N-1:0]   vec_q, vec_d;
    logic           s_q, s_d;
    logic           vec_valid_q, vec_valid_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;
    logic [N:0]     ones_q, ones_d;
    logic [N:0]     err_q, err_d;
    logic           flag_q, flag_d;
    logic [N-1:0]   first_q, first_d;
    logic           cur;

    // Next-state and next-register values; every output is registered from these.
    always_comb begin
        state_d     = state_q;
        tt_d        = tt_q;
        exp_d       = exp_q;
        idx_d       = idx_q;
        vec_d       = vec_q;
        s_d         = s_q;
        vec_valid_d = 1'b0;
        done_d      = 1'b0;
        ones_d      = ones_q;
        err_d       = err_q;
        flag_d      = flag_q;
        first_d     = first_q;
        cur         = tt_q[idx_q];

        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    tt_d = bus.tt_in;
                end
                if (bus.start) begin
                    exp_d   = bus.exp_in;
                    idx_d   = '0;
                    ones_d  = '0;
                    err_d   = '0;
                    flag_d  = 1'b0;
                    first_d = '0;
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                vec_d       = idx_q;
                s_d         = cur;
                vec_valid_d = 1'b1;
                ones_d      = ones_q + (N+1)'(cur);
                if (cur != exp_q[idx_q]) begin
                    err_d = err_q + (N+1)'(1);
                    // Only the lowest failing vector is kept; vectors arrive in ascending order.
                    if (!flag_q) begin
                        first_d = idx_q;
                        flag_d  = 1'b1;
                    end
                end
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + N'(1);
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tt_q        <= '0;
            exp_q       <= '0;
            idx_q       <= '0;
            vec_q       <= '0;
            s_q         <= 1'b0;
            vec_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ones_q      <= '0;
            err_q       <= '0;
            flag_q      <= 1'b0;
            first_q     <= '0;
        end else begin
            state_q     <= state_d;
            tt_q        <= tt_d;
            exp_q       <= exp_d;
            idx_q       <= idx_d;
            vec_q       <= vec_d;
            s_q         <= s_d;
            vec_valid_q <= vec_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            ones_q      <= ones_d;
            err_q       <= err_d;
            flag_q      <= flag_d;
            first_q     <= first_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.vec       = vec_q;
    assign bus.s         = s_q;
    assign bus.vec_valid = vec_valid_q;
    assign bus.done      = done_q;
    assign bus.ones_cnt  = ones_q;
    assign bus.err_cnt   = err_q;
    assign bus.err_flag  = flag_q;
    assign bus.first_err = first_q;
endmodule

// File: tb/tb_tt_sweeper.sv
// Bench for tt_sweeper: a cycle-indexed reference model for the N=4 instance
// checked every cycle, plus literal expectations and a small N=2 instance.
module tb_tt_sweeper;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    tt_sweeper_if #(.N(4)) b4 ();
    tt_sweeper_if #(.N(2)) b2 ();

    tt_sweeper #(.N(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
    tt_sweeper #(.N(2)) u2 (.clk(clk), .rst(rst), .bus(b2));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    // Reference model: k counts cycles since the accepted start (-1 = idle).
    int          k = -1;
    logic [15:0] m_tt = '0, m_exp = '0;
    logic [3:0]  e_vec = '0, e_first = '0;
    logic        e_s = 1'b0, e_flag = 1'b0;
    logic [4:0]  e_ones = '0, e_err = '0;

    always @(posedge clk) begin
        if (rst) begin
            k = -1; m_tt = '0; m_exp = '0;
            e_vec = '0; e_s = 1'b0; e_ones = '0; e_err = '0; e_flag = 1'b0; e_first = '0;
        end else if (k < 0 || k == W + 1) begin
            k = -1;
            if (b4.load) m_tt = b4.tt_in;
            if (b4.start) begin
                m_exp = b4.exp_in;
                k = 0;
                e_ones = '0; e_err = '0; e_flag = 1'b0; e_first = '0;
            end
        end else begin
            k++;
            if (k <= W) begin
                e_vec = 4'(k - 1);
                e_s   = m_tt[k-1];
                e_ones = '0; e_err = '0; e_flag = 1'b0; e_first = '0;
                for (int j = 0; j < k; j++) begin
                    e_ones += 5'(m_tt[j]);
                    if (m_tt[j] != m_exp[j]) begin
                        if (!e_flag) e_first = 4'(j);
                        e_flag = 1'b1;
                        e_err += 5'd1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of the N=4 instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",      32'(b4.busy),      32'(k >= 0 && k <= W));
            chk("vec_valid", 32'(b4.vec_valid), 32'(k >= 1 && k <= W));
            chk("done",      32'(b4.done),      32'(k == W + 1));
            chk("vec",       32'(b4.vec),       32'(e_vec));
            chk("s",         32'(b4.s),         32'(e_s));
            chk("ones_cnt",  32'(b4.ones_cnt),  32'(e_ones));
            chk("err_cnt",   32'(b4.err_cnt),   32'(e_err));
            chk("err_flag",  32'(b4.err_flag),  32'(e_flag));
            chk("first_err", 32'(b4.first_err), 32'(e_first));
        end
    end

    task automatic start4(input logic [15:0] tt, input logic [15:0] ex);
        b4.load = 1'b1; b4.tt_in = tt;
        @(negedge clk);
        b4.load = 1'b0;
        b4.start = 1'b1; b4.exp_in = ex;
        @(negedge clk);
        b4.start = 1'b0;
    endtask

    task automatic wait_done4(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (b4.done) begin
                n = i;
                break;
            end
        end
        chk("done_seen", 32'(n > 0), 32'd1);
    endtask

    task automatic wait_vec4(input int v);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b4.vec_valid && b4.vec == 4'(v)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_vec", 32'(ok), 32'd1);
    endtask

    task automatic results4(input string tag, input int ones, input int err, input int flag, input int first);
        chk({tag, "_ones"},  32'(b4.ones_cnt),  32'(ones));
        chk({tag, "_err"},   32'(b4.err_cnt),   32'(err));
        chk({tag, "_flag"},  32'(b4.err_flag),  32'(flag));
        chk({tag, "_first"}, 32'(b4.first_err), 32'(first));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] s2_exp;
        s2_exp = 4'b0110;
        b4.load = 1'b0; b4.start = 1'b0; b4.tt_in = '0; b4.exp_in = '0;
        b2.load = 1'b0; b2.start = 1'b0; b2.tt_in = '0; b2.exp_in = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        chk("rst_busy", 32'(b4.busy), 32'd0);
        chk("rst_done", 32'(b4.done), 32'd0);
        results4("rst", 0, 0, 0, 0);

        // Matching table: 8 ones, no errors, done 17 cycles after the start edge.
        start4(16'hE8E8, 16'hE8E8);
        wait_done4(n);
        chk("t1_latency", 32'(n), 32'd17);
        results4("t1", 8, 0, 0, 0);
        chk("t1_last_vec", 32'(b4.vec), 32'd15);
        chk("t1_last_s", 32'(b4.s), 32'd1);

        // Two mismatches at vectors 0 and 7.
        start4(16'hE8E8, 16'hE869);
        wait_done4(n);
        results4("t2", 8, 2, 1, 0);
        repeat (3) @(negedge clk);
        results4("t2_hold", 8, 2, 1, 0);

        // All ones against all zeros, then all zeros.
        start4(16'hFFFF, 16'h0000);
        wait_done4(n);
        results4("t3a", 16, 16, 1, 0);
        start4(16'h0000, 16'h0000);
        wait_done4(n);
        results4("t3b", 0, 0, 0, 0);

        // load/start while busy are ignored.
        start4(16'hE8E8, 16'hE8E8);
        wait_vec4(5);
        b4.start = 1'b1; b4.load = 1'b1; b4.tt_in = 16'h1234; b4.exp_in = 16'h0000;
        @(negedge clk);
        b4.start = 1'b0; b4.load = 1'b0;
        wait_done4(n);
        results4("t4", 8, 0, 0, 0);

        // Reset mid-sweep: everything clears, no done pulse.
        start4(16'hE8E8, 16'h0000);
        wait_vec4(9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy", 32'(b4.busy), 32'd0);
        chk("t5_valid", 32'(b4.vec_valid), 32'd0);
        chk("t5_vec", 32'(b4.vec), 32'd0);
        chk("t5_s", 32'(b4.s), 32'd0);
        results4("t5", 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t5_no_done", 32'(b4.done), 32'd0);
        end

        // load and start together: sweep uses the new table.
        b4.load = 1'b1; b4.tt_in = 16'h8000;
        b4.start = 1'b1; b4.exp_in = 16'h8000;
        @(negedge clk);
        b4.load = 1'b0; b4.start = 1'b0;
        wait_done4(n);
        chk("t6_latency", 32'(n), 32'd17);
        results4("t6", 1, 0, 0, 0);
        chk("t6_last_s", 32'(b4.s), 32'd1);

        // N=2 instance: XOR table.
        chk("n2_rst_ones", 32'(b2.ones_cnt), 32'd0);
        b2.load = 1'b1; b2.tt_in = 4'b0110;
        @(negedge clk);
        b2.load = 1'b0;
        b2.start = 1'b1; b2.exp_in = 4'b0110;
        @(negedge clk);
        b2.start = 1'b0;
        chk("n2_busy", 32'(b2.busy), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i <= 4) begin
                chk("n2_valid", 32'(b2.vec_valid), 32'd1);
                chk("n2_vec", 32'(b2.vec), 32'(i - 1));
                chk("n2_s", 32'(b2.s), 32'(s2_exp[i-1]));
                chk("n2_done_low", 32'(b2.done), 32'd0);
            end else begin
                chk("n2_done", 32'(b2.done), 32'd1);
                chk("n2_valid_low", 32'(b2.vec_valid), 32'd0);
            end
        end
        chk("n2_ones", 32'(b2.ones_cnt), 32'd2);
        chk("n2_err", 32'(b2.err_cnt), 32'd0);
        chk("n2_flag", 32'(b2.err_flag), 32'd0);
        @(negedge clk);
        chk("n2_done_pulse", 32'(b2.done), 32'd0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tt_sweeper.md
Name: tt_sweeper

Overview:
Parametrised sequential truth-table engine for N-input Boolean functions. It holds a loadable 2^N-bit truth table and, on start, sweeps every input vector 0..2^N-1, one per clock. For each vector it emits the function output and checks it against an expected table. It reports the ones count, mismatch count and first failing vector, so exhaustive gate-level checks run in hardware instead of in hand-written stimulus lists.

Parameters:
N, 4, number of function inputs (1..8); table width is 2^N, counters are N+1 bits.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
load  in  1  write tt_in into the truth-table register
tt_in  in  2^N  truth table; bit i = output for input vector i
exp_in  in  2^N  expected table, sampled when start is accepted
start  in  1  begin sweep
busy  out  1  high in SWEEP and DONE
vec  out  N  current input vector
s  out  1  function output for vec (tt[vec])
vec_valid  out  1  vec/s valid this cycle
done  out  1  one-cycle pulse at end of sweep
ones_cnt  out  N+1  number of vectors with s=1
err_cnt  out  N+1  number of vectors with s != exp[vec]
err_flag  out  1  at least one mismatch this sweep
first_err  out  N  lowest vector index that mismatched (0 if none)

Behaviour:
- Synchronous active-high reset, one clock, on rst=1 at a clock edge:
  - state <= IDLE.
  - tt, exp, idx, vec, s, vec_valid, done, busy, ones_cnt, err_cnt, err_flag and first_err all <= 0.
  - rst overrides every other input, including mid-sweep; no done pulse is generated.
- All outputs are registered.
- States: IDLE, SWEEP, DONE.
- IDLE:
  - load=1: tt <= tt_in.
  - start=1: exp <= exp_in; idx <= 0; ones_cnt, err_cnt, err_flag and first_err cleared; go to SWEEP.
  - load and start in the same cycle: the sweep uses the newly loaded tt_in.
- SWEEP, each cycle:
  - vec <= idx, s <= tt[idx], vec_valid <= 1.
  - ones_cnt += tt[idx].
  - If tt[idx] != exp[idx]: err_cnt += 1; if err_flag=0 then first_err <= idx and err_flag <= 1.
  - Counters therefore include vector k in the same cycle that vector k appears on vec.
  - If idx == 2^N-1, go to DONE; otherwise idx += 1 (no wrap).
- DONE: done=1 and vec_valid=0 for exactly one cycle, then return to IDLE.
- Latency: with start accepted at edge t, vectors appear at t+1..t+2^N and done at t+2^N+1. Counters are final while done=1.
- Results (ones_cnt, err_cnt, err_flag, first_err, last vec/s) hold in IDLE until the next accepted start.
- start and load are ignored in SWEEP and DONE; a sweep cannot be restarted or retabled while busy.
- Counter range: 0..2^N fits in N+1 bits with no overflow; all ones gives ones_cnt = 2^N.
- vec_valid is 0 in IDLE and DONE.

Test Plan:
- N=4; load tt=16'hE8E8, start with exp=16'hE8E8 -> vec 0..15 on consecutive cycles, s = tt[vec]; done at t+17; ones_cnt=8, err_cnt=0, err_flag=0, first_err=0.
- N=4; tt=16'hE8E8, exp=16'hE869 -> err_cnt=2 (vectors 0 and 7), err_flag=1, first_err=0; ones_cnt=8.
- N=4; tt=16'hFFFF, exp=16'h0000 -> ones_cnt=5'b10000, err_cnt=16, first_err=0.
  Then tt=16'h0000 -> ones_cnt=0, err_cnt=0.
- N=4; sweep running, assert start and load (tt_in=16'h1234) at vec=5 -> both ignored, sweep finishes with the original table.
  Then raise rst at vec=9 of a new sweep -> next cycle all outputs 0, IDLE, no done pulse.
- N=2 instance; tt=4'b0110, exp=4'b0110 -> vec/s sequence 0/0, 1/1, 2/1, 3/0; done at t+5; ones_cnt=2, err_cnt=0.
- N=4; load (tt_in=16'h8000) and start with exp=16'h8000 in the same IDLE cycle -> sweep uses 16'h8000: s=1 only at vec=15, ones_cnt=1, err_cnt=0.
